// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester UART 8N1 transmitter with round-robin arbitration and message locking.
// Define UART_ARB_FIXED_PRI_EN to make requester 0 win every unlocked tie.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] req0_msg,
  input  logic       req0_val,
  input  logic       req0_last,
  output logic       req0_rdy,
  input  logic [7:0] req1_msg,
  input  logic       req1_val,
  input  logic       req1_last,
  output logic       req1_rdy,
  output logic       tx,
  output logic [1:0] grant,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shreg_q;
  logic [1:0]  grant_q;
  logic        tx_q, lock_q, owner_q, last_q, fin_q;
  logic        pri0, idle, acc0, acc1, sel_last, bit_end;
`ifdef UART_ARB_FIXED_PRI_EN
  assign pri0 = 1'b1;
`else
  assign pri0 = last_q;
`endif
  assign idle     = state_q == IDLE && !reset;
  // under a lock the owner alone is ready, independent of either val
  assign req0_rdy = idle && (lock_q ? !owner_q : req0_val && (!req1_val || pri0));
  assign req1_rdy = idle && (lock_q ? owner_q : req1_val && (!req0_val || !pri0));
  assign acc0     = req0_val && req0_rdy;
  assign acc1     = req1_val && req1_rdy;
  assign sel_last = acc1 ? req1_last : req0_last;
  assign bit_end  = cnt_q == 16'(CLKS_PER_BIT - 1);
  assign tx       = tx_q;
  assign grant    = reset ? 2'b00 : grant_q;
  assign busy     = !reset && (state_q != IDLE || lock_q);
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      fin_q   <= 1'b0;
      grant_q <= 2'b00;
    end else begin
      cnt_q <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 16'd1;
      case (state_q)
        IDLE: if (acc0 || acc1) begin
          state_q <= START;
          tx_q    <= 1'b0;
          idx_q   <= '0;
          shreg_q <= acc1 ? req1_msg : req0_msg;
          fin_q   <= sel_last;
          owner_q <= acc1;
          last_q  <= acc1;
          grant_q <= acc1 ? 2'b10 : 2'b01;
          if (!sel_last) lock_q <= 1'b1;
        end
        START: if (bit_end) begin
          state_q <= DATA;
          tx_q    <= shreg_q[0];
        end
        DATA: if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            idx_q   <= idx_q + 3'd1;
            shreg_q <= shreg_q >> 1;
            tx_q    <= shreg_q[1];
          end
        end
        STOP: if (bit_end) begin
          state_q <= IDLE;
          if (fin_q) begin
            lock_q  <= 1'b0;
            grant_q <= 2'b00;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 347, clock cycles per UART bit; 347 gives 115200 baud at 40 MHz; legal range 4 to 65535.
REQ-002 The block SHALL have port clock, input, 1, single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports req0_msg / req1_msg, input, 8, byte from requester 0 / 1.
REQ-005 The block SHALL have ports req0_val / req1_val, input, 1, byte valid.
REQ-006 The block SHALL have ports req0_last / req1_last, input, 1, byte ends the requester's message; sampled with msg.
REQ-007 The block SHALL have ports req0_rdy / req1_rdy, output, 1, block accepts the byte this cycle.
REQ-008 The block SHALL have port tx, output, 1, serial 8N1 line, idle high.
REQ-009 The block SHALL have port grant, output, 2, one-hot current owner; 2'b00 when unowned.
REQ-010 The block SHALL have port busy, output, 1, high whenever state is not IDLE or a message lock is held.

Function
REQ-011 The block SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-012 A byte SHALL be accepted only in a cycle where reqN_val and reqN_rdy are both high, with IDLE -> START on the next edge.
REQ-013 reqN_rdy SHALL be high only in IDLE and only for the winner; it SHALL not depend combinationally on reqN_val of the other requester when a lock is held.
REQ-014 Arbitration with no lock SHALL be round-robin, so that on simultaneous val the requester not granted most recently wins; a lone val wins immediately.
REQ-015 When a byte is accepted with last=0, the block SHALL lock the grant to that requester, and the other requester's rdy SHALL stay low until release, even while the owner's val is low.
REQ-016 The lock SHALL release on the edge that leaves STOP for a byte accepted with last=1, with grant going to 2'b00 if no new win occurs.
REQ-017 tx SHALL be low for CLKS_PER_BIT cycles in START.
REQ-018 In DATA, tx SHALL drive msg bits 0..7, LSB first, each for CLKS_PER_BIT cycles.
REQ-019 tx SHALL be high for CLKS_PER_BIT cycles in STOP, after which the FSM returns to IDLE.
REQ-020 One frame SHALL be exactly 10*CLKS_PER_BIT cycles from the first START cycle.
REQ-021 The FSM SHALL spend at least one cycle in IDLE between frames, so back-to-back bytes are spaced 10*CLKS_PER_BIT+1 cycles apart.
REQ-022 tx SHALL be registered, with no glitches and no combinational path from inputs.
REQ-023 The accepted byte SHALL be captured in an internal shift register; requester inputs SHALL be ignored outside the accept cycle.
REQ-024 The bit counter SHALL be 16 bits wide, and the bit index SHALL be 3 bits wide, ending DATA after index 7.

Reset
REQ-025 While reset is high, the block SHALL drive tx=1, busy=0, grant=2'b00 and req0_rdy=req1_rdy=0.
REQ-026 Reset SHALL set the FSM to IDLE, clear the lock and counters, and set last-granted to requester 1, so requester 0 wins the first tie.
REQ-027 Reset asserted mid-frame SHALL abort the frame, with tx=1 on the next edge and the partial byte discarded.
REQ-028 After reset deasserts, a byte SHALL be accepted in the first cycle val is high.

Configuration
REQ-029 Macro UART_ARB_FIXED_PRI_EN SHALL select the arbitration policy.
REQ-030 With UART_ARB_FIXED_PRI_EN defined, requester 0 SHALL always win unlocked ties, while lock semantics stay unchanged.
REQ-031 Without UART_ARB_FIXED_PRI_EN, the round-robin policy of REQ-014 SHALL apply.

Verification (CLKS_PER_BIT=4)
REQ-032 req0 sends 0xA5 with last=1 -> tx shows 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; 40 cycles total; grant returns to 00.
REQ-033 Both val high with last=1 from reset, req0=0x11 and req1=0x22 -> 0x11 sent then 0x22; with the macro defined and req0 held valid, 0x11 is sent twice before 0x22.
REQ-034 req0 sends 0x01 (last=0), drops val for 20 cycles, then sends 0x02 (last=1), while req1 holds val with 0x33 -> req1_rdy stays low until 0x02 stop ends; tx order is 0x01, 0x02, 0x33.
REQ-035 reset pulsed at cycle 15 of a 0xFF frame -> tx=1 on the next edge, busy=0, and no further bits are sent; the next byte is accepted the first cycle after reset.
REQ-036 req1 streams 3 bytes with val continuously high -> accepts spaced exactly 41 cycles apart, and the start bit follows each accept by 1 cycle.
